// File: rtl/key4_debounce_onehot.sv
// Four-key synchronizer, whole-vector debouncer and one-hot event capture FSM.
// Optional macro AUTO_REPEAT_EN re-presents a held key every REPEAT_CYCLES cycles.
module key4_debounce_onehot #(
    parameter int DEB_CYCLES    = 16,
    parameter int CNT_W         = 8,
    parameter int REPEAT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_raw,
    output logic [3:0] onehot,
    output logic       valid,
    input  logic       ack,
    output logic       multi,
    output logic       busy
);

    // Handshake: valid stays high with onehot/multi stable until ack is sampled
    // high on a rising edge; ack has no effect while valid is low.

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [3:0]       s1, s2;
    logic [3:0]       candidate;
    logic [3:0]       debounced;
    logic [CNT_W-1:0] cnt;

    state_t     state, state_n;
    logic [3:0] onehot_n;
    logic       valid_n;
    logic       multi_n;
    logic [3:0] pri;
    logic       pri_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
        end
    end

    // Any difference between the synchronized vector and the candidate restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate <= '0;
            cnt       <= '0;
            debounced <= '0;
        end else if (s2 != candidate) begin
            candidate <= s2;
            cnt       <= '0;
        end else if (cnt < CNT_W'(DEB_CYCLES - 1)) begin
            cnt <= cnt + 1'b1;
        end else begin
            debounced <= candidate;
        end
    end

    always_comb begin
        pri = 4'b0000;
        if (debounced[3])      pri = 4'b1000;
        else if (debounced[2]) pri = 4'b0100;
        else if (debounced[1]) pri = 4'b0010;
        else if (debounced[0]) pri = 4'b0001;
    end

    assign pri_multi = ($countones(debounced) > 1);

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;

    logic [REP_W-1:0] rep_cnt;
    logic [3:0]       deb_prev;
    logic [3:0]       last_onehot;
    logic             last_multi;
    logic             rep_run;
    logic             rep_fire;

    assign rep_run  = (state == WAIT_REL) && (debounced != 4'b0000) && (debounced == deb_prev);
    // Fires after REPEAT_CYCLES-1 cycles in WAIT_REL so that, with ack held high,
    // consecutive valid pulses are exactly REPEAT_CYCLES cycles apart.
    assign rep_fire = rep_run && (rep_cnt == REP_W'(REPEAT_CYCLES - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt     <= '0;
            deb_prev    <= '0;
            last_onehot <= '0;
            last_multi  <= 1'b0;
        end else begin
            deb_prev <= debounced;
            if (rep_run && !rep_fire) rep_cnt <= rep_cnt + 1'b1;
            else                      rep_cnt <= '0;
            if (state == IDLE && debounced != 4'b0000) begin
                last_onehot <= pri;
                last_multi  <= pri_multi;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            onehot <= '0;
            valid  <= 1'b0;
            multi  <= 1'b0;
        end else begin
            state  <= state_n;
            onehot <= onehot_n;
            valid  <= valid_n;
            multi  <= multi_n;
        end
    end

    always_comb begin
        state_n  = state;
        onehot_n = onehot;
        valid_n  = valid;
        multi_n  = multi;
        case (state)
            IDLE: begin
                if (debounced != 4'b0000) begin
                    onehot_n = pri;
                    multi_n  = pri_multi;
                    valid_n  = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                // The held event ignores debounced entirely; only ack retires it.
                if (valid && ack) begin
                    onehot_n = 4'b0000;
                    multi_n  = 1'b0;
                    valid_n  = 1'b0;
                    state_n  = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (debounced == 4'b0000) begin
                    state_n = IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (rep_fire) begin
                    onehot_n = last_onehot;
                    multi_n  = last_multi;
                    valid_n  = 1'b1;
                    state_n  = HOLD;
                end
`endif
            end
            default: begin
                state_n  = IDLE;
                onehot_n = 4'b0000;
                multi_n  = 1'b0;
                valid_n  = 1'b0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
